pwm_multi: RTL
==============

# pwm_multi

Multi-channel, parametrised PWM generator for the switch/LED datapath, driven from the 100 MHz board clock. CHANNELS outputs share one prescaler and one period counter. Each channel has its own double-buffered duty register, and new duties take effect only at a period boundary, so outputs never glitch. It supports edge-aligned and centre-aligned modes, and the duty range is exact: 0 gives fully off.

## Interface
- CHANNELS, 4, number of PWM outputs.
- WIDTH, 8, duty/counter width; MAX = 2^WIDTH−1.
- PRESCALE, 512, clk cycles per counter tick (≥1); the defaults give 100 MHz/(256·512) ≈ 762.9 Hz edge-mode period.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  1 = run counters; 0 = counters held at 0, outputs 0.
- center_mode  in  1  0 = edge-aligned, 1 = centre-aligned; sampled with `load`.
- duty_in  in  CHANNELS·WIDTH  channel i duty at bits [i·WIDTH +: WIDTH].
- load  in  1  one-cycle strobe: capture duty_in and center_mode into shadow.
- pwm_out  out  CHANNELS  registered PWM outputs.
- pending  out  1  shadow holds a value not yet applied.
- period_start  out  1  one-cycle pulse on each boundary.

## Operation
- **Reset values:** prescaler, cnt, dir (up), shadow, active, mode are all 0. pwm_out, pending and period_start are 0.
- **Prescaler:** counts 0..PRESCALE−1. `tick` is asserted in the cycle it equals PRESCALE−1, and the prescaler wraps to 0 in that cycle. With PRESCALE = 1, tick is asserted every cycle.
- **Edge mode:** cnt advances 0..MAX on each tick. Boundary = tick with cnt==MAX, after which cnt becomes 0. Period = 2^WIDTH ticks. pwm_out[i] <= enable && cnt < active[i]. High time = duty ticks, so duty 0 is always low and MAX gives MAX/2^WIDTH.
- **Centre mode:** the count sequence is 0,1..MAX,MAX−1..1,0, and dir flips at MAX and at 0. Boundary = tick with cnt==1 and dir down. Period = 2·MAX ticks. The compare is the same. High time = 2·duty−1 ticks for duty ≥ 1, and 0 for duty 0.
- **Load:** when load=1, shadow <= duty_in, shadow_mode <= center_mode, and pending <= 1.
- **Boundary:** active <= shadow, mode <= shadow_mode, and pending <= 0 unless load is also asserted in that cycle.
  - If load and boundary coincide, the transfer uses the old shadow. The new value lands in shadow and pending stays 1, so it applies at the next boundary.
- **Mode switch:** on a switch, cnt restarts at 0 with dir up.
- **Disabled (enable=0):**
  - prescaler, cnt and dir are held at 0/up; pwm_out is 0; period_start is 0.
  - Loads are still accepted, and shadow transfers to active the cycle after load, so pending clears.
  - On re-enable, counting starts from cnt=0 with the current active values.
- **Mid-operation reset:** everything returns to reset values immediately and asynchronously. pwm_out drops in the same cycle without waiting for a clock edge.

## Timing
- pwm_out has one cycle of latency from the cnt value: the compare is registered.
- period_start is asserted in the cycle after the boundary tick, coincident with active updating.
- The first pwm_out using a new duty appears one cycle after period_start.
- load → pending=1 one cycle later.
- duty_in and center_mode are sampled only on load.

## Structure
- Shared package `pwm_pkg`: mode encoding constants (PWM_EDGE = 0, PWM_CENTER = 1) and a function computing period length in ticks from WIDTH/mode for the bench.
- One natural sub-module, `pwm_timebase`: the prescaler plus up/down counter. Its outputs are cnt, tick and boundary.
- The per-channel compare and shadow logic stays in pwm_multi as a generate loop.

## Test plan
Bench parameters: CHANNELS=2, WIDTH=4, PRESCALE=2.
- **Reset:** assert rst mid-period → pwm_out=0, pending=0 and period_start=0 immediately. After release the first period starts at cnt=0.
- **Edge mode, duties {0,15}:** ch0 is never high; ch1 is high 30 clk per 32 clk period. Then duties {8,4} → 16 and 8 clk high respectively.
- **Double buffering:** load duty 3 mid-period while active=10 → the current period keeps 10 (20 clk high). The next period shows 6 clk high; pending falls together with period_start.
- **Load on boundary cycle:** strobe load exactly on the boundary tick → the old shadow is applied, pending stays 1, and the new value applies one period later.
- **Centre mode, duty 5:** period 60 clk. Output high is centred on cnt=0, lasting 9 ticks = 18 clk. duty 15 → 29 ticks high.
- **enable=0:** pwm_out is held at 0 and cnt at 0. A load while disabled clears pending the next cycle. After re-enable, the first period uses the loaded duty with the full period length.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode and
// counter-direction encodings plus a period-length helper.
package pwm_pkg;

  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;

  // Period length in counter ticks for a given counter width and mode.
  function automatic int unsigned pwm_period_ticks(input int unsigned width,
                                                   input logic        mode);
    int unsigned max_v;
    max_v = (32'd1 << width) - 32'd1;
    return (mode == PWM_CENTER) ? (32'd2 * max_v) : (max_v + 32'd1);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared timebase: prescaler producing a tick every PRESCALE clocks and a
// period counter that runs saw-tooth (edge mode) or triangle (centre mode).
// o_boundary marks the tick that closes a period; the counter is back at 0
// with direction up on the following cycle.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tick,
  output logic             o_boundary
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [PS_W-1:0]  r_ps;
  logic [WIDTH-1:0] r_cnt;
  logic             r_dir;
  logic             w_tick;
  logic             w_last;
  logic             w_boundary;

  assign w_tick     = i_enable && (r_ps == PS_LAST);
  // Last count of a period: MAX going up (edge) or 1 going down (centre).
  assign w_last     = (i_mode == PWM_EDGE) ? (r_cnt == CNT_MAX)
                                           : ((r_cnt == CNT_ONE) && (r_dir == DIR_DOWN));
  assign w_boundary = w_tick && w_last;

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps <= '0;
    end else if (!i_enable || w_tick) begin
      r_ps <= '0;
    end else begin
      r_ps <= r_ps + 1'b1;
    end
  end

  // Period counter and direction. A mode change only ever lands at a
  // boundary or while disabled, and both leave the counter at 0/up, so a
  // switch always restarts cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else if (!i_enable) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else if (w_tick) begin
      if (w_last) begin
        r_cnt <= '0;
        r_dir <= DIR_UP;
      end else if (i_mode == PWM_EDGE) begin
        r_cnt <= r_cnt + 1'b1;
        r_dir <= DIR_UP;
      end else if (r_dir == DIR_UP) begin
        if (r_cnt == CNT_MAX) begin
          r_cnt <= CNT_MAX - 1'b1;
          r_dir <= DIR_DOWN;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_cnt      = r_cnt;
  assign o_tick     = w_tick;
  assign o_boundary = w_boundary;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. All channels share one timebase; each
// channel has a shadow duty that is copied to its active duty only at a
// period boundary (or straight away while disabled), so outputs never
// glitch mid-period.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      center_mode,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      pending,
  output logic                      period_start
);

  logic [WIDTH-1:0]          w_cnt_p0;
  logic                      w_tick;
  logic                      w_boundary;
  logic                      w_period_end;
  logic                      w_xfer;
  logic [CHANNELS-1:0]       w_hit_p0;

  logic [CHANNELS*WIDTH-1:0] r_shadow;
  logic                      r_shadow_mode;
  logic [CHANNELS*WIDTH-1:0] r_active;
  logic                      r_mode;
  logic                      r_pending;
  logic                      r_period_start;
  logic [CHANNELS-1:0]       r_pwm_p1;

  pwm_timebase #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (enable),
    .i_mode     (r_mode),
    .o_cnt      (w_cnt_p0),
    .o_tick     (w_tick),
    .o_boundary (w_boundary)
  );

  // The boundary is only ever raised on a tick; both are named here so the
  // period-end condition reads as it is meant.
  assign w_period_end = w_tick && w_boundary;

  // While disabled there is no boundary to wait for, so a pending shadow is
  // applied on the next cycle instead.
  assign w_xfer = w_period_end || (!enable && r_pending);

  // Shadow capture: duty_in and center_mode are only looked at on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_shadow_mode <= PWM_EDGE;
    end else if (load) begin
      r_shadow      <= duty_in;
      r_shadow_mode <= center_mode;
    end
  end

  // Active transfer. A load coinciding with the transfer still hands over
  // the previous shadow; the new value waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= '0;
      r_mode   <= PWM_EDGE;
    end else if (w_xfer) begin
      r_active <= r_shadow;
      r_mode   <= r_shadow_mode;
    end
  end

  // Pending flag: a fresh load wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (load) begin
      r_pending <= 1'b1;
    end else if (w_xfer) begin
      r_pending <= 1'b0;
    end
  end

  // Period-start pulse, aligned with the cycle the active duties change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period_start <= 1'b0;
    end else begin
      r_period_start <= w_period_end;
    end
  end

  // ---- stage p0 -> p1: per-channel compare against the shared count ----
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign w_hit_p0[g] = (w_cnt_p0 < r_active[g*WIDTH +: WIDTH]);
  end

  // Registered outputs, forced low whenever the generator is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_p1 <= '0;
    end else begin
      r_pwm_p1 <= enable ? w_hit_p0 : '0;
    end
  end

  assign pwm_out      = r_pwm_p1;
  assign pending      = r_pending;
  assign period_start = r_period_start;

endmodule
